// File: rtl/h2_chan_sched.sv
// h2_chan_sched: four-channel round-robin scheduler feeding one shared
// first-difference stage y = 2*x - 2*h[c], where h[c] holds the last sample
// accepted from channel c.
// Each sample passes through IDLE (arbitrate/accept), CALC (compute and
// update history) and OUT (hold the result until downstream takes it).
// Optional build macro H2_SCHED_SAT_EN: clamp the result to the signed DW-bit
// range instead of wrapping it.
module h2_chan_sched #(
    parameter int DW = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [3:0]        req_valid,
    input  logic [4*DW-1:0]   req_data,
    output logic [3:0]        req_ready,
    input  logic [3:0]        chan_en,
    input  logic              clr_hist,
    output logic              out_valid,
    output logic [1:0]        out_chan,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [DW-1:0] x_q, x_d;
    logic [1:0]    c_q, c_d;
    logic [DW-1:0] h_q [4];
    logic [DW-1:0] h_d [4];
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_chan_q, out_chan_d;

    logic [3:0]    eligible;
    logic [1:0]    cand;
    logic [1:0]    grant_idx;
    logic          grant_found;
    logic          accept;
    logic [DW+1:0] x_ext;
    logic [DW+1:0] h_ext;
    logic [DW-1:0] y;

    // Round-robin search: scan offsets from the far end down to zero so the
    // eligible channel nearest to ptr (inclusive) is the one left standing.
    always_comb begin
        eligible    = req_valid & chan_en;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot ready only for the winner while idle, suppressed during reset.
    always_comb begin
        req_ready = 4'b0000;
        if (!reset && (state_q == ST_IDLE) && grant_found) begin
            req_ready = 4'b0001 << grant_idx;
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign x_ext     = {{2{x_q[DW-1]}}, x_q};
    assign h_ext     = {{2{h_q[c_q][DW-1]}}, h_q[c_q]};
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef H2_SCHED_SAT_EN
    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};
    logic signed [DW+1:0] diff;

    // Difference computed with two guard bits, then clamped to the DW-bit range.
    always_comb begin
        diff = $signed((x_ext << 1) - (h_ext << 1));
        if (diff > SAT_MAX) begin
            y = SAT_MAX[DW-1:0];
        end else if (diff < SAT_MIN) begin
            y = SAT_MIN[DW-1:0];
        end else begin
            y = diff[DW-1:0];
        end
    end
`else
    // Difference computed with two guard bits and truncated (wraps mod 2^DW).
    always_comb begin
        y = DW'((x_ext << 1) - (h_ext << 1));
    end
`endif

    // Next-state logic for the FSM, the sample latch, the result registers
    // and the history; a history clear overrides the CALC write.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        x_d        = x_q;
        c_d        = c_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        h_d        = h_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CALC;
                    x_d     = req_data[int'(grant_idx)*DW +: DW];
                    c_d     = grant_idx;
                    ptr_d   = grant_idx + 2'd1;
                end
            end
            ST_CALC: begin
                out_data_d = y;
                out_chan_d = c_q;
                h_d[c_q]   = x_q;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clr_hist) begin
            for (int i = 0; i < 4; i++) begin
                h_d[i] = '0;
            end
        end
    end

    // State registers with synchronous reset that beats everything else.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            x_q        <= '0;
            c_q        <= 2'd0;
            out_data_q <= '0;
            out_chan_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            x_q        <= x_d;
            c_q        <= c_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= h_d[i];
            end
        end
    end

endmodule

// File: tb/tb_h2_chan_sched.sv
// Testbench for h2_chan_sched (DW=16): directed steps with a scoreboard of
// expected results filled at accept time and drained as results leave.
// Honours H2_SCHED_SAT_EN in its reference model.
module tb_h2_chan_sched;

    logic        CLK;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  chan_en;
    logic        clr_hist;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [15:0] out_data;
    logic        out_ready;

    typedef struct {
        logic [1:0]  chan;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] hist [4];
    int          total;
    int          bad;

    h2_chan_sched #(.DW(16)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .chan_en   (chan_en),
        .clr_hist  (clr_hist),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model of one filter step: 2*x - 2*h, wrapped or clamped.
    function automatic logic [15:0] modelY(input logic [15:0] x, input logic [15:0] h);
        int d;
        d = 2 * int'($signed(x)) - 2 * int'($signed(h));
`ifdef H2_SCHED_SAT_EN
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
`endif
        return d[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) hist[i] = 16'h0000;
    endtask

    // Drive requests, check the grant, record the expected result, then walk
    // through the accept and CALC cycles; returns with the DUT in OUT.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] en,
                                 input int expChan, input logic [15:0] sample,
                                 input bit clrInCalc);
        exp_t e;
        for (int n = 0; n < 4; n++) req_data[n*16 +: 16] = 16'h1111 * 16'(n + 1);
        req_data[expChan*16 +: 16] = sample;
        req_valid = valid;
        chan_en   = en;
        #1;
        checkOutput("grant", {28'h0, req_ready}, 32'h1 << expChan);
        e.chan = 2'(expChan);
        e.data = modelY(sample, hist[expChan]);
        sb.push_back(e);
        hist[expChan] = sample;
        tick();
        clr_hist = clrInCalc;
        #1;
        checkOutput("calc_ready", {28'h0, req_ready}, 32'h0);
        checkOutput("calc_valid", {31'h0, out_valid}, 32'h0);
        if (clrInCalc) clearModel();
        tick();
        clr_hist = 1'b0;
    endtask

    // Hold the result for holdCycles with out_ready low, then take it.
    task automatic drainOut(input int holdCycles);
        exp_t e;
        for (int i = 0; i < holdCycles; i++) begin
            out_ready = 1'b0;
            #1;
            checkOutput("hold_valid", {31'h0, out_valid}, 32'h1);
            checkOutput("hold_data", {16'h0, out_data}, {16'h0, sb[0].data});
            checkOutput("hold_ready", {28'h0, req_ready}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("out_valid", {31'h0, out_valid}, 32'h1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL sb_empty: observed=output expected=none");
        end else begin
            e = sb.pop_front();
            checkOutput("out_data", {16'h0, out_data}, {16'h0, e.data});
            checkOutput("out_chan", {30'h0, out_chan}, {30'h0, e.chan});
        end
        tick();
        checkOutput("done_valid", {31'h0, out_valid}, 32'h0);
    endtask

    // Linear sequence of directed steps.
    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        chan_en   = 4'hF;
        clr_hist  = 1'b0;
        out_ready = 1'b1;
        clearModel();

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_chan", {30'h0, out_chan}, 32'h0);
        checkOutput("rst_data", {16'h0, out_data}, 32'h0);
        checkOutput("rst_ready", {28'h0, req_ready}, 32'h0);
        reset     = 1'b0;
        req_valid = 4'h0;
        tick();

        $display("[TB] channel 0 basic samples");
        applyStimulus(4'b0001, 4'hF, 0, 16'h0010, 1'b0);
        checkOutput("c0_first", {16'h0, sb[0].data}, 32'h0020);
        drainOut(0);
        applyStimulus(4'b0001, 4'hF, 0, 16'h0030, 1'b0);
        checkOutput("c0_second", {16'h0, sb[0].data}, 32'h0040);
        drainOut(0);

        $display("[TB] round-robin from ptr=1 picks channel 3 over 0");
        applyStimulus(4'b1001, 4'hF, 3, 16'h0100, 1'b0);
        drainOut(0);

        $display("[TB] all requests high");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'hF, 4'hF, k % 4, 16'h0200 + 16'(k * 16'h0123), 1'b0);
            drainOut(0);
        end

        $display("[TB] enable mask 1010");
        applyStimulus(4'hF, 4'b1010, 1, 16'h0AAA, 1'b0);
        drainOut(0);
        applyStimulus(4'hF, 4'b1010, 3, 16'h0BBB, 1'b0);
        drainOut(0);
        applyStimulus(4'hF, 4'b1010, 1, 16'h0CCC, 1'b0);
        drainOut(0);

        $display("[TB] no eligible request");
        req_valid = 4'hF;
        chan_en   = 4'h0;
        #1;
        checkOutput("idle_noen_ready", {28'h0, req_ready}, 32'h0);
        tick();
        req_valid = 4'h0;
        chan_en   = 4'hF;
        #1;
        checkOutput("idle_noreq_ready", {28'h0, req_ready}, 32'h0);
        tick();
        checkOutput("idle_valid", {31'h0, out_valid}, 32'h0);

        $display("[TB] back-pressure");
        applyStimulus(4'b0001, 4'hF, 0, 16'h0055, 1'b0);
        req_valid = 4'hF;
        drainOut(5);

        $display("[TB] history clear while idle");
        req_valid = 4'h0;
        clr_hist  = 1'b1;
        tick();
        clr_hist  = 1'b0;
        clearModel();
        applyStimulus(4'b0001, 4'hF, 0, 16'h0003, 1'b0);
        checkOutput("clr_idle_exp", {16'h0, sb[0].data}, 32'h0006);
        drainOut(0);

        $display("[TB] history clear during CALC");
        applyStimulus(4'b0001, 4'hF, 0, 16'h0007, 1'b1);
        drainOut(0);
        applyStimulus(4'b0001, 4'hF, 0, 16'h0001, 1'b0);
        checkOutput("clr_calc_exp", {16'h0, sb[0].data}, 32'h0002);
        drainOut(0);

        $display("[TB] channel 2 overflow boundary");
        applyStimulus(4'b0100, 4'hF, 2, 16'hC000, 1'b0);
        drainOut(0);
        applyStimulus(4'b0100, 4'hF, 2, 16'h4000, 1'b0);
`ifdef H2_SCHED_SAT_EN
        checkOutput("ovf_exp", {16'h0, sb[0].data}, 32'h7FFF);
`else
        checkOutput("ovf_exp", {16'h0, sb[0].data}, 32'h0000);
`endif
        drainOut(0);

        $display("[TB] reset during OUT");
        applyStimulus(4'b0010, 4'hF, 1, 16'h0123, 1'b0);
        #1;
        checkOutput("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        reset     = 1'b1;
        req_valid = 4'hF;
        tick();
        checkOutput("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("mid_rst_data", {16'h0, out_data}, 32'h0);
        checkOutput("mid_rst_ready", {28'h0, req_ready}, 32'h0);
        reset     = 1'b0;
        req_valid = 4'h0;
        sb.delete();
        clearModel();
        tick();
        applyStimulus(4'b0010, 4'hF, 1, 16'h0005, 1'b0);
        checkOutput("post_rst_exp", {16'h0, sb[0].data}, 32'h000A);
        drainOut(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/h2_chan_sched.md
H2_CHAN_SCHED -- requirements
Module: h2_chan_sched

Interface
REQ-001 The block SHALL have parameter DW, default 16: sample and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 4: per-channel sample-present flags.
REQ-005 The block SHALL have port req_data, input, 4*DW: channel n's sample at bits [n*DW +: DW], two's complement.
REQ-006 The block SHALL have port req_ready, output, 4: one-hot acceptance strobe.
REQ-007 The block SHALL have port chan_en, input, 4: channel enable mask.
REQ-008 The block SHALL have port clr_hist, input, 1: clears all channel history.
REQ-009 The block SHALL have port out_valid, output, 1: result present.
REQ-010 The block SHALL have port out_chan, output, 2: channel index of the result.
REQ-011 The block SHALL have port out_data, output, DW: filtered result.
REQ-012 The block SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-013 The block SHALL time-share one difference stage y = 2*x - 2*h[c] across 4 channels, where h[c] is channel c's last accepted sample.
REQ-014 The FSM SHALL have states IDLE, CALC and OUT; transitions SHALL be IDLE->CALC on accept, CALC->OUT unconditionally, and OUT->IDLE when out_ready=1.
REQ-015 In IDLE, grant SHALL go to the first channel n with req_valid[n]=1 and chan_en[n]=1, searching round-robin from ptr.
REQ-016 req_ready[n] SHALL be combinational, high only in IDLE for the granted n; accept means req_valid[n] & req_ready[n].
REQ-017 On accept, the block SHALL latch x and c and set ptr=(c+1) mod 4.
REQ-018 In CALC, the block SHALL register y into out_data and c into out_chan, and write h[c]=x.
REQ-019 out_valid SHALL be 1 exactly while in OUT; out_data and out_chan SHALL stay stable until the transfer completes.
REQ-020 Latency from accept cycle to out_valid SHALL be 2 cycles; peak throughput SHALL be 1 sample per 3 cycles.
REQ-021 Arithmetic SHALL be performed in DW+2 bits; the result SHALL wrap mod 2^DW unless REQ-029 applies.
REQ-022 A channel with chan_en=0 SHALL never be granted; its h value SHALL be retained.
REQ-023 Changing chan_en SHALL take effect at the next IDLE arbitration.
REQ-024 clr_hist=1 SHALL zero all h[] on that edge in any state.
REQ-025 If clr_hist=1 coincides with a CALC write, clear SHALL win (h[c]=0); the in-flight y SHALL be unaffected.
REQ-026 With no eligible request in IDLE, the block SHALL stay in IDLE with req_ready=0.

Reset
REQ-027 When reset=1, the block SHALL enter IDLE with ptr=0, all h[]=0, out_valid=0, out_chan=0, out_data=0 and req_ready=0.
REQ-028 Reset SHALL override clr_hist and any in-flight transfer, and SHALL drop out_valid on the next edge even mid-OUT.

Configuration
REQ-029 With macro H2_SCHED_SAT_EN defined, the block SHALL clamp the DW+2-bit result to [-2^(DW-1), 2^(DW-1)-1] (0x8000..0x7FFF for DW=16); without the macro, the block SHALL wrap per REQ-021 and include no clamp logic.

Verification
REQ-030 The bench SHALL drive ch0 samples 0x0010 then 0x0030 after reset and require out_data 0x0020 then 0x0040, out_chan=0, out_valid 2 cycles after each accept.
REQ-031 The bench SHALL hold all four req_valid with out_ready=1 and require grant order 0,1,2,3,0 with one accept per 3 cycles.
REQ-032 The bench SHALL set chan_en=4'b1010 with all requests high and require grants to alternate 1,3,1 only.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in OUT and require out_valid/out_data held and req_ready=0 throughout, with the transfer completing on the cycle out_ready rises.
REQ-034 The bench SHALL drive ch2 samples 0xC000 then 0x4000 and require 0x0000 without H2_SCHED_SAT_EN and 0x7FFF with it.
REQ-035 The bench SHALL assert reset during OUT, then send ch1 0x0005, and require out_valid=0 after the reset edge and then out_data 0x000A (history cleared).
